// File: rtl/nc2_pkg.sv
// Shared types for the bit-serial two's-complement sign unit: mode codes,
// FSM state encoding and the per-operation negate decode.
package nc2_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_PASS = 2'b00;
  localparam mode_t MODE_NEG  = 2'b01;
  localparam mode_t MODE_ABS  = 2'b10;
  localparam mode_t MODE_NABS = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } state_e;

  // Whether the operand must be negated, given the mode and its sign bit.
  function automatic logic neg_decode(input mode_t mode, input logic sign);
    logic neg;
    neg = 1'b0;
    unique case (mode)
      MODE_PASS: neg = 1'b0;
      MODE_NEG:  neg = 1'b1;
      MODE_ABS:  neg = sign;
      MODE_NABS: neg = ~sign;
      default:   neg = 1'b0;
    endcase
    return neg;
  endfunction

  // Only negate and abs can produce an unrepresentable result.
  function automatic logic ovf_mode(input mode_t mode);
    return (mode == MODE_NEG) || (mode == MODE_ABS);
  endfunction

endpackage

// File: rtl/nc2_neg_bitcell.sv
// One-bit serial negator cell: copy bits up to and including the first one,
// invert every bit after it. The seen-one flag is registered by the parent.
module nc2_neg_bitcell (
  input  logic b,
  input  logic neg_en,
  input  logic seen_one_in,
  output logic out_bit,
  output logic seen_one_out
);

  assign out_bit      = (neg_en && seen_one_in) ? ~b : b;
  assign seen_one_out = seen_one_in | b;

endmodule

// File: rtl/nc2_abs_serial.sv
// Bit-serial pass/negate/abs/nabs unit, LSB first, one bit per clock.
// Optional saturation on overflow is enabled by defining NC2_ABS_SAT_EN.
module nc2_abs_serial
  import nc2_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] x,
  input  logic [1:0]   mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] z,
  output logic         ovf
);

  localparam int unsigned CW = $clog2(N + 1);
  localparam logic [CW-1:0] CntMax = CW'(N);
  localparam logic [N-1:0] MostNeg = {1'b1, {(N-1){1'b0}}};

  state_e         state_q, state_d;
  logic [N-1:0]   sr_q, sr_d;
  logic [N-1:0]   res_q, res_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           seen_q, seen_d;
  logic           neg_en_q, neg_en_d;
  logic           ovf_cand_q, ovf_cand_d;
  logic [N-1:0]   z_q, z_d;
  logic           ovf_q, ovf_d;

  logic           cell_out;
  logic           cell_seen;

  nc2_neg_bitcell u_cell (
    .b            (sr_q[0]),
    .neg_en       (neg_en_q),
    .seen_one_in  (seen_q),
    .out_bit      (cell_out),
    .seen_one_out (cell_seen)
  );

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    res_d      = res_q;
    cnt_d      = cnt_q;
    seen_d     = seen_q;
    neg_en_d   = neg_en_q;
    ovf_cand_d = ovf_cand_q;
    z_d        = z_q;
    ovf_d      = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          sr_d       = x;
          neg_en_d   = neg_decode(mode_t'(mode), x[N-1]);
          ovf_cand_d = ovf_mode(mode_t'(mode)) && (x == MostNeg);
          cnt_d      = '0;
          seen_d     = 1'b0;
          state_d    = StShift;
        end
      end
      StShift: begin
        if (cnt_q == CntMax) begin
          // Result only becomes visible once all N bits are assembled.
          z_d   = res_q;
          ovf_d = ovf_cand_q;
`ifdef NC2_ABS_SAT_EN
          if (ovf_cand_q) begin
            z_d = {1'b0, {(N-1){1'b1}}};
          end
`endif
          state_d = StDone;
        end else begin
          res_d  = {cell_out, res_q[N-1:1]};
          sr_d   = {1'b0, sr_q[N-1:1]};
          seen_d = cell_seen;
          cnt_d  = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      sr_q       <= '0;
      res_q      <= '0;
      cnt_q      <= '0;
      seen_q     <= 1'b0;
      neg_en_q   <= 1'b0;
      ovf_cand_q <= 1'b0;
      z_q        <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      res_q      <= res_d;
      cnt_q      <= cnt_d;
      seen_q     <= seen_d;
      neg_en_q   <= neg_en_d;
      ovf_cand_q <= ovf_cand_d;
      z_q        <= z_d;
      ovf_q      <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign z         = z_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_nc2_abs_serial.sv
// Directed self-checking bench for nc2_abs_serial with N=8.
module tb_nc2_abs_serial;

  localparam int unsigned N = 8;

  logic         clock;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] x;
  logic [1:0]   mode;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] z;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  nc2_abs_serial #(.N(N)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .ovf       (ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, check latency and result, then drain it.
  task automatic do_op(input string tag, input logic [7:0] xv, input logic [1:0] mv,
                       input logic [7:0] exp_z, input logic exp_ovf);
    int cyc;
    @(negedge clock);
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    x = xv;
    mode = mv;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    x = 8'h5A;
    mode = 2'b00;
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'(N + 1));
    check({tag, " z"}, 32'(z), 32'(exp_z));
    check({tag, " ovf"}, 32'(ovf), 32'(exp_ovf));
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    check({tag, " drained"}, {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  initial begin
    logic [7:0] held_z;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x         = '0;
    mode      = '0;
    reset     = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst z", 32'(z), 32'd0);
    check("rst ovf", 32'(ovf), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    do_op("abs F3", 8'hF3, 2'b10, 8'h0D, 1'b0);
    do_op("neg 05", 8'h05, 2'b01, 8'hFB, 1'b0);
    do_op("nabs 05", 8'h05, 2'b11, 8'hFB, 1'b0);
    do_op("nabs FB", 8'hFB, 2'b11, 8'hFB, 1'b0);
`ifdef NC2_ABS_SAT_EN
    do_op("abs 80", 8'h80, 2'b10, 8'h7F, 1'b1);
    do_op("neg 80", 8'h80, 2'b01, 8'h7F, 1'b1);
`else
    do_op("abs 80", 8'h80, 2'b10, 8'h80, 1'b1);
    do_op("neg 80", 8'h80, 2'b01, 8'h80, 1'b1);
`endif
    do_op("nabs 80", 8'h80, 2'b11, 8'h80, 1'b0);
    do_op("pass 00", 8'h00, 2'b00, 8'h00, 1'b0);
    do_op("neg 00", 8'h00, 2'b01, 8'h00, 1'b0);
    do_op("abs 00", 8'h00, 2'b10, 8'h00, 1'b0);
    do_op("nabs 00", 8'h00, 2'b11, 8'h00, 1'b0);
    do_op("pass A5", 8'hA5, 2'b00, 8'hA5, 1'b0);
    do_op("neg 01", 8'h01, 2'b01, 8'hFF, 1'b0);
    do_op("abs 7F", 8'h7F, 2'b10, 8'h7F, 1'b0);

    // Back-pressure: hold DONE while a new operand is offered.
    @(negedge clock);
    x = 8'h0C;
    mode = 2'b01;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (N + 1) @(posedge clock);
    #1;
    check("stall enter", 32'(out_valid), 32'd1);
    check("stall z", 32'(z), 32'hF4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      x = 8'h33;
      mode = 2'b01;
      in_valid = 1'b1;
      @(posedge clock);
      #1;
      check("stall hold", {22'd0, out_valid, in_ready, z}, {22'd0, 1'b1, 1'b0, 8'hF4});
    end
    @(negedge clock);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    check("stall release", {30'd0, out_valid, in_ready}, 32'b01);
    check("stall z kept", 32'(z), 32'hF4);
    @(posedge clock);
    #1;
    check("no ghost op", 32'(in_ready), 32'd1);

    // Reset in the middle of SHIFT discards the operation.
    @(negedge clock);
    x = 8'h81;
    mode = 2'b10;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("midrst state", {30'd0, out_valid, in_ready}, 32'b01);
    check("midrst z", 32'(z), 32'd0);
    check("midrst ovf", 32'(ovf), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    do_op("abs FF", 8'hFF, 2'b10, 8'h01, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
